pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Parametrised successor to the single-cycle decoder. Decodes the ID-stage instruction and carries the control
//  bundle down ID/EX -> EX/MEM -> MEM/WB registers. Adds load-use stall and taken-branch/jump flush.
//  Sits beside the 5-stage datapath and feeds each stage's muxes, ALU and memory from the matching register.
// PARAMETERS
//  ALUOP_W   5   ALU operation code width; encodings are the team's ALUOp table.
//  REG_W     5   register-address width.
//  CNT_W     16  performance-counter width (used only with PERF_CNT_EN).
// PORTS
//  Clk           in   1        rising-edge clock
//  Rst_n         in   1        asynchronous active-low reset
//  IDInstr       in   32       instruction held in the IF/ID register
//  BranchTaken   in   1        EX/MEM branch resolved taken, or jr/j target valid
//  PCWrite       out  1        0 = hold PC (stall)
//  IFIDWrite     out  1        0 = hold IF/ID (stall)
//  IFIDFlush     out  1        1 = load NOP into IF/ID
//  EX_ALUOp      out  ALUOP_W  EX-stage ALU operation
//  EX_ALUSrc, EX_ShiftA, EX_Branch, EX_JorBranch, EX_Jump   out 1 each   EX-stage controls
//  EX_RegDst     out  2        00 = rt, 01 = rd, 10 = $31 (jal)
//  EX_DstReg     out  REG_W    resolved destination register number
//  MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf      out 1 each   MEM-stage controls
//  WB_RegWrite, WB_MemToReg, WB_Link                        out 1 each   WB controls; Link = write PC+8
//  WB_DstReg     out  REG_W    writeback destination
//  IllegalInstr  out  1        registered; unknown opcode or funct reached EX
//  StallCnt, FlushCnt          out CNT_W each   only when PERF_CNT_EN
// BEHAVIOUR
//  Decode (combinational, ID)
//  - R-type: add/sub/and/or/nor/xor/slt/sll/srl/jr.
//  - I-type: addi/andi/ori/xori/slti, lw/lb/lh/sw/sb/sh, beq/bne/bgtz/blez.
//  - REGIMM (opcode 000001): rt = 00001 -> bgez, rt = 00000 -> bltz; any other rt is illegal.
//  - J-type: j (no RegWrite), jal (RegWrite, RegDst = 10, Link).
//  - Unknown opcode or funct -> all-zero bundle plus illegal flag. sll with instr == 0 is a NOP: RegWrite = 0.
//  Pipeline
//  - Each clock: ID bundle -> ID/EX, ID/EX -> EX/MEM, EX/MEM -> MEM/WB.
//  - Latency: ID decode appears on EX_* 1 cycle later, MEM_* 2 cycles later, WB_* 3 cycles later.
//  Load-use hazard (combinational)
//  - Condition: ID/EX.MemRead && ID/EX.DstReg != 0 && (DstReg == IDInstr.rs || (DstReg == IDInstr.rt && ID uses rt)).
//  - Response: PCWrite = 0, IFIDWrite = 0, and a bubble (all-zero bundle) is loaded into ID/EX.
//  - Stall lasts exactly 1 cycle per load-use pair.
//  Flush
//  - BranchTaken = 1: IFIDFlush = 1; bubbles loaded into ID/EX and EX/MEM; PCWrite = 1 (target loads).
//  - MEM/WB advances normally.
//  - Flush and stall in the same cycle: flush wins, no stall.
//  Bubble definition: every control bit 0, DstReg 0, ALUOp 0.
//  Reset
//  - Asynchronous reset clears every pipeline register to a bubble and IllegalInstr to 0.
//  - PCWrite = 1, IFIDWrite = 1, IFIDFlush = 0.
//  - Reset mid-operation discards all in-flight control; no write or memory enable survives.
// CONFIGURATION
//  PERF_CNT_EN defined
//  - StallCnt increments on each stall cycle; FlushCnt increments on each BranchTaken cycle.
//  - Both saturate at all-ones and clear on reset.
//  PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package pcu_pkg
//  - Opcode and funct localparams, ALUOp encodings, RegDst encodings.
//  - ctrl_bundle_t packed struct.
//  - BUBBLE constant.
//  Sub-module control_decode: pure combinational decode, IDInstr -> ctrl_bundle_t + illegal.
//  Top module: stage registers, hazard compare, flush/stall muxing.
// TESTING
//  1. add $3,$1,$2 in ID -> next cycle EX_ALUOp = 00000, EX_RegDst = 01, EX_DstReg = 3; WB_RegWrite = 1 after 3 cycles.
//  2. lw $5,0($1) then add $6,$5,$2
//     -> one cycle with PCWrite = 0, IFIDWrite = 0 and an EX bubble; add then reaches EX with DstReg = 6.
//  3. lw $0,... then add using $0 -> no stall.
//  4. beq in EX/MEM with BranchTaken = 1 while a load-use is pending
//     -> IFIDFlush = 1, EX_* and MEM_* all 0 next cycle, no stall.
//  5. Opcode 000001 with rt = 1 vs rt = 0 -> EX_ALUOp 01110 vs 01001, both with EX_Branch = 1.
//     rt = 2 -> IllegalInstr = 1 and a bubble.
//  6. jal -> WB_Link = 1, WB_DstReg = 31.
//     Assert Rst_n = 0 mid-stream -> all outputs return to reset values immediately, without waiting for Clk.
//     With PERF_CNT_EN: after scenarios 2 and 4, StallCnt = 1 and FlushCnt = 1.

Source files
------------

// File: rtl/pcu_pkg.sv
// rtl/pcu_pkg.sv - opcode/funct/ALUOp/RegDst encodings and the control bundle carried down the pipeline.
package pcu_pkg;

    localparam int PCU_ALUOP_W = 5;
    localparam int PCU_REG_W   = 5;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [PCU_ALUOP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [PCU_ALUOP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [PCU_ALUOP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [PCU_ALUOP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [PCU_ALUOP_W-1:0] ALU_NOR  = 5'd4;
    localparam logic [PCU_ALUOP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [PCU_ALUOP_W-1:0] ALU_SLT  = 5'd6;
    localparam logic [PCU_ALUOP_W-1:0] ALU_SLL  = 5'd7;
    localparam logic [PCU_ALUOP_W-1:0] ALU_SRL  = 5'd8;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BLTZ = 5'd9;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BEQ  = 5'd10;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BNE  = 5'd11;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BGTZ = 5'd12;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BLEZ = 5'd13;
    localparam logic [PCU_ALUOP_W-1:0] ALU_BGEZ = 5'd14;
    localparam logic [PCU_ALUOP_W-1:0] ALU_JR   = 5'd15;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [PCU_REG_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [PCU_ALUOP_W-1:0] alu_op;
        logic                   alu_src;
        logic                   shift_a;
        logic                   branch;
        logic                   jor_branch;
        logic                   jump;
        logic [1:0]             reg_dst;
        logic [PCU_REG_W-1:0]   dst_reg;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_byte;
        logic                   mem_half;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic                   link;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational ID-stage decode of one instruction into a control bundle.
module control_decode
    import pcu_pkg::*;
(
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_ctrl,
    output logic         o_uses_rt,
    output logic         o_illegal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;

    assign w_op    = i_instr[31:26];
    assign w_rt    = i_instr[20:16];
    assign w_rd    = i_instr[15:11];
    assign w_funct = i_instr[5:0];

    ctrl_bundle_t w_c;
    logic         w_ill;
    logic         w_uses_rt;

    always_comb begin
        w_c       = BUBBLE;
        w_ill     = 1'b0;
        w_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_c.reg_write = 1'b1;
                w_c.reg_dst   = REGDST_RD;
                w_uses_rt     = 1'b1;
                case (w_funct)
                    FN_ADD: w_c.alu_op = ALU_ADD;
                    FN_SUB: w_c.alu_op = ALU_SUB;
                    FN_AND: w_c.alu_op = ALU_AND;
                    FN_OR:  w_c.alu_op = ALU_OR;
                    FN_NOR: w_c.alu_op = ALU_NOR;
                    FN_XOR: w_c.alu_op = ALU_XOR;
                    FN_SLT: w_c.alu_op = ALU_SLT;
                    FN_SLL: begin w_c.alu_op = ALU_SLL; w_c.shift_a = 1'b1; end
                    FN_SRL: begin w_c.alu_op = ALU_SRL; w_c.shift_a = 1'b1; end
                    FN_JR: begin
                        w_c.alu_op     = ALU_JR;
                        w_c.jump       = 1'b1;
                        w_c.jor_branch = 1'b1;
                        w_c.reg_write  = 1'b0;
                        w_c.reg_dst    = REGDST_RT;
                        w_uses_rt      = 1'b0;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                w_c.branch     = 1'b1;
                w_c.jor_branch = 1'b1;
                case (w_rt)
                    RT_BGEZ: w_c.alu_op = ALU_BGEZ;
                    RT_BLTZ: w_c.alu_op = ALU_BLTZ;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_J: begin
                w_c.jump       = 1'b1;
                w_c.jor_branch = 1'b1;
            end
            OP_JAL: begin
                w_c.jump       = 1'b1;
                w_c.jor_branch = 1'b1;
                w_c.reg_write  = 1'b1;
                w_c.reg_dst    = REGDST_RA;
                w_c.link       = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                w_c.branch     = 1'b1;
                w_c.jor_branch = 1'b1;
                w_uses_rt      = (w_op == OP_BEQ) || (w_op == OP_BNE);
                case (w_op)
                    OP_BEQ:  w_c.alu_op = ALU_BEQ;
                    OP_BNE:  w_c.alu_op = ALU_BNE;
                    OP_BLEZ: w_c.alu_op = ALU_BLEZ;
                    default: w_c.alu_op = ALU_BGTZ;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                w_c.alu_src   = 1'b1;
                w_c.reg_write = 1'b1;
                case (w_op)
                    OP_SLTI: w_c.alu_op = ALU_SLT;
                    OP_ANDI: w_c.alu_op = ALU_AND;
                    OP_ORI:  w_c.alu_op = ALU_OR;
                    OP_XORI: w_c.alu_op = ALU_XOR;
                    default: w_c.alu_op = ALU_ADD;
                endcase
            end
            OP_LB, OP_LH, OP_LW: begin
                w_c.alu_src    = 1'b1;
                w_c.mem_read   = 1'b1;
                w_c.mem_to_reg = 1'b1;
                w_c.reg_write  = 1'b1;
                w_c.mem_byte   = (w_op == OP_LB);
                w_c.mem_half   = (w_op == OP_LH);
            end
            OP_SB, OP_SH, OP_SW: begin
                w_c.alu_src   = 1'b1;
                w_c.mem_write = 1'b1;
                w_c.mem_byte  = (w_op == OP_SB);
                w_c.mem_half  = (w_op == OP_SH);
                w_uses_rt     = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase

        // The all-zero word is sll $0,$0,0; treat it as a true NOP so it leaves no trace.
        if (w_ill || (i_instr == 32'd0)) begin
            w_c       = BUBBLE;
            w_uses_rt = 1'b0;
        end

        if (!w_c.reg_write)
            w_c.dst_reg = '0;
        else if (w_c.reg_dst == REGDST_RD)
            w_c.dst_reg = w_rd;
        else if (w_c.reg_dst == REGDST_RA)
            w_c.dst_reg = REG_RA;
        else
            w_c.dst_reg = w_rt;
    end

    assign o_ctrl    = w_c;
    assign o_uses_rt = w_uses_rt;
    assign o_illegal = w_ill;

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and branch flush.
// Optional stall/flush performance counters are built when PERF_CNT_EN is defined.
module pipelined_control_unit
    import pcu_pkg::*;
#(
    parameter int ALUOP_W = PCU_ALUOP_W,
    parameter int REG_W   = PCU_REG_W
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [31:0]        IDInstr,
    input  logic               BranchTaken,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IFIDFlush,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic               EX_ALUSrc,
    output logic               EX_ShiftA,
    output logic               EX_Branch,
    output logic               EX_JorBranch,
    output logic               EX_Jump,
    output logic [1:0]         EX_RegDst,
    output logic [REG_W-1:0]   EX_DstReg,
    output logic               MEM_MemRead,
    output logic               MEM_MemWrite,
    output logic               MEM_MemByte,
    output logic               MEM_MemHalf,
    output logic               WB_RegWrite,
    output logic               WB_MemToReg,
    output logic               WB_Link,
    output logic [REG_W-1:0]   WB_DstReg,
    output logic               IllegalInstr
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   FlushCnt
`endif
);

    ctrl_bundle_t w_id_ctrl;
    logic         w_id_uses_rt;
    logic         w_id_illegal;

    control_decode u_decode (
        .i_instr   (IDInstr),
        .o_ctrl    (w_id_ctrl),
        .o_uses_rt (w_id_uses_rt),
        .o_illegal (w_id_illegal)
    );

    ctrl_bundle_t         r_idex;
    ctrl_bundle_t         r_exmem;
    logic                 r_ex_illegal;
    logic                 r_wb_reg_write;
    logic                 r_wb_mem_to_reg;
    logic                 r_wb_link;
    logic [PCU_REG_W-1:0] r_wb_dst;

    logic w_load_use;
    logic w_stall;
    logic w_flush;

    assign w_load_use = r_idex.mem_read && (r_idex.dst_reg != '0) &&
                        ((r_idex.dst_reg == IDInstr[25:21]) ||
                         (w_id_uses_rt && (r_idex.dst_reg == IDInstr[20:16])));
    assign w_flush    = BranchTaken;
    // A taken branch discards the dependent instruction anyway, so it overrides the stall.
    assign w_stall    = w_load_use && !w_flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_idex          <= BUBBLE;
            r_exmem         <= BUBBLE;
            r_ex_illegal    <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_link       <= 1'b0;
            r_wb_dst        <= '0;
        end else begin
            r_idex          <= (w_flush || w_stall) ? BUBBLE : w_id_ctrl;
            r_ex_illegal    <= (w_flush || w_stall) ? 1'b0 : w_id_illegal;
            r_exmem         <= w_flush ? BUBBLE : r_idex;
            r_wb_reg_write  <= r_exmem.reg_write;
            r_wb_mem_to_reg <= r_exmem.mem_to_reg;
            r_wb_link       <= r_exmem.link;
            r_wb_dst        <= r_exmem.dst_reg;
        end
    end

    assign PCWrite      = !w_stall;
    assign IFIDWrite    = !w_stall;
    assign IFIDFlush    = w_flush && Rst_n;

    assign EX_ALUOp     = ALUOP_W'(r_idex.alu_op);
    assign EX_ALUSrc    = r_idex.alu_src;
    assign EX_ShiftA    = r_idex.shift_a;
    assign EX_Branch    = r_idex.branch;
    assign EX_JorBranch = r_idex.jor_branch;
    assign EX_Jump      = r_idex.jump;
    assign EX_RegDst    = r_idex.reg_dst;
    assign EX_DstReg    = REG_W'(r_idex.dst_reg);
    assign IllegalInstr = r_ex_illegal;

    assign MEM_MemRead  = r_exmem.mem_read;
    assign MEM_MemWrite = r_exmem.mem_write;
    assign MEM_MemByte  = r_exmem.mem_byte;
    assign MEM_MemHalf  = r_exmem.mem_half;

    assign WB_RegWrite  = r_wb_reg_write;
    assign WB_MemToReg  = r_wb_mem_to_reg;
    assign WB_Link      = r_wb_link;
    assign WB_DstReg    = REG_W'(r_wb_dst);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed table and sequence checks for pipelined_control_unit.
module tb_pipelined_control_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] IDInstr;
    logic        BranchTaken;
    logic        PCWrite, IFIDWrite, IFIDFlush;
    logic [4:0]  EX_ALUOp;
    logic        EX_ALUSrc, EX_ShiftA, EX_Branch, EX_JorBranch, EX_Jump;
    logic [1:0]  EX_RegDst;
    logic [4:0]  EX_DstReg;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf;
    logic        WB_RegWrite, WB_MemToReg, WB_Link;
    logic [4:0]  WB_DstReg;
    logic        IllegalInstr;
`ifdef PERF_CNT_EN
    logic [15:0] StallCnt, FlushCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    pipelined_control_unit dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .IDInstr      (IDInstr),
        .BranchTaken  (BranchTaken),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .EX_ALUOp     (EX_ALUOp),
        .EX_ALUSrc    (EX_ALUSrc),
        .EX_ShiftA    (EX_ShiftA),
        .EX_Branch    (EX_Branch),
        .EX_JorBranch (EX_JorBranch),
        .EX_Jump      (EX_Jump),
        .EX_RegDst    (EX_RegDst),
        .EX_DstReg    (EX_DstReg),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemByte  (MEM_MemByte),
        .MEM_MemHalf  (MEM_MemHalf),
        .WB_RegWrite  (WB_RegWrite),
        .WB_MemToReg  (WB_MemToReg),
        .WB_Link      (WB_Link),
        .WB_DstReg    (WB_DstReg),
        .IllegalInstr (IllegalInstr)
`ifdef PERF_CNT_EN
        ,
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
`endif
    );

    // exf = {ALUSrc, ShiftA, Branch, JorBranch, Jump, Illegal}; memf = {Read, Write, Byte, Half}; wbf = {RegWrite, MemToReg, Link}
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [1:0]  rdst;
        logic [4:0]  dst;
        logic [5:0]  exf;
        logic [3:0]  memf;
        logic [2:0]  wbf;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vt [NVEC];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic logic [31:0] ex_grp();
        return {14'd0, EX_ALUOp, EX_RegDst, EX_DstReg, EX_ALUSrc, EX_ShiftA,
                EX_Branch, EX_JorBranch, EX_Jump, IllegalInstr};
    endfunction

    function automatic logic [31:0] mem_grp();
        return {28'd0, MEM_MemRead, MEM_MemWrite, MEM_MemByte, MEM_MemHalf};
    endfunction

    function automatic logic [31:0] wb_grp();
        return {24'd0, WB_RegWrite, WB_MemToReg, WB_Link, WB_DstReg};
    endfunction

    function automatic logic [31:0] ctl_grp();
        return {29'd0, PCWrite, IFIDWrite, IFIDFlush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n       = 1'b0;
        IDInstr     = 32'd0;
        BranchTaken = 1'b0;
        #2;
        Rst_n       = 1'b1;
    endtask

    initial begin
        Rst_n       = 1'b0;
        IDInstr     = 32'd0;
        BranchTaken = 1'b0;
        tick();
        tick();
        chk("reset_ex",  ex_grp(),  32'd0);
        chk("reset_mem", mem_grp(), 32'd0);
        chk("reset_wb",  wb_grp(),  32'd0);
        chk("reset_ctl", ctl_grp(), 32'b110);
        Rst_n = 1'b1;

        vt[0]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),      5'd0,  2'b01, 5'd3,  6'b000000, 4'b0000, 3'b100};
        vt[1]  = '{rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22),      5'd1,  2'b01, 5'd4,  6'b000000, 4'b0000, 3'b100};
        vt[2]  = '{rtype(5'd0, 5'd2, 5'd7, 5'd3, 6'h00),      5'd7,  2'b01, 5'd7,  6'b010000, 4'b0000, 3'b100};
        vt[3]  = '{itype(6'h08, 5'd1, 5'd8, 16'd5),           5'd0,  2'b00, 5'd8,  6'b100000, 4'b0000, 3'b100};
        vt[4]  = '{itype(6'h23, 5'd1, 5'd9, 16'd4),           5'd0,  2'b00, 5'd9,  6'b100000, 4'b1000, 3'b110};
        vt[5]  = '{itype(6'h28, 5'd1, 5'd2, 16'd0),           5'd0,  2'b00, 5'd0,  6'b100000, 4'b0110, 3'b000};
        vt[6]  = '{itype(6'h04, 5'd1, 5'd2, 16'd8),           5'd10, 2'b00, 5'd0,  6'b001100, 4'b0000, 3'b000};
        vt[7]  = '{itype(6'h01, 5'd3, 5'd1, 16'd4),           5'd14, 2'b00, 5'd0,  6'b001100, 4'b0000, 3'b000};
        vt[8]  = '{itype(6'h01, 5'd3, 5'd0, 16'd4),           5'd9,  2'b00, 5'd0,  6'b001100, 4'b0000, 3'b000};
        vt[9]  = '{itype(6'h01, 5'd3, 5'd2, 16'd4),           5'd0,  2'b00, 5'd0,  6'b000001, 4'b0000, 3'b000};
        vt[10] = '{jtype(6'h03, 26'h100),                     5'd0,  2'b10, 5'd31, 6'b000110, 4'b0000, 3'b101};
        vt[11] = '{itype(6'h21, 5'd1, 5'd10, 16'd2),          5'd0,  2'b00, 5'd10, 6'b100000, 4'b1001, 3'b110};
        vt[12] = '{32'd0,                                     5'd0,  2'b00, 5'd0,  6'b000000, 4'b0000, 3'b000};
        vt[13] = '{itype(6'h0E, 5'd1, 5'd11, 16'd7),          5'd5,  2'b00, 5'd11, 6'b100000, 4'b0000, 3'b100};
        vt[14] = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F),      5'd0,  2'b00, 5'd0,  6'b000001, 4'b0000, 3'b000};
        vt[15] = '{rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08),     5'd15, 2'b00, 5'd0,  6'b000110, 4'b0000, 3'b000};

        for (int i = 0; i < NVEC; i++) begin
            IDInstr     = vt[i].instr;
            BranchTaken = 1'b0;
            #1;
            chk($sformatf("vec%0d_ctl", i), ctl_grp(), 32'b110);
            tick();
            chk($sformatf("vec%0d_ex", i), ex_grp(),
                {14'd0, vt[i].alu, vt[i].rdst, vt[i].dst, vt[i].exf});
            if (i >= 1)
                chk($sformatf("vec%0d_mem", i - 1), mem_grp(), {28'd0, vt[i-1].memf});
            if (i >= 2)
                chk($sformatf("vec%0d_wb", i - 2), wb_grp(), {24'd0, vt[i-2].wbf, vt[i-2].dst});
        end

        // Load-use: lw $5 then add $6,$5,$2
        do_reset();
        IDInstr = itype(6'h23, 5'd1, 5'd5, 16'd0);
        tick();
        IDInstr = rtype(5'd5, 5'd2, 5'd6, 5'd0, 6'h20);
        #1;
        chk("lduse_stall_ctl", ctl_grp(), 32'b000);
        tick();
        chk("lduse_ex_bubble", ex_grp(), 32'd0);
        chk("lduse_mem_read", mem_grp(), 32'b1000);
        #1;
        chk("lduse_one_cycle", ctl_grp(), 32'b110);
        tick();
        chk("lduse_add_ex", {27'd0, EX_RegDst, EX_DstReg}, {27'd0, 2'b01, 5'd6});

        // Taken branch while a load-use is pending: flush wins
        IDInstr = itype(6'h08, 5'd1, 5'd8, 16'd5);
        tick();
        IDInstr = itype(6'h23, 5'd1, 5'd5, 16'd0);
        tick();
        IDInstr     = rtype(5'd5, 5'd2, 5'd6, 5'd0, 6'h20);
        BranchTaken = 1'b1;
        #1;
        chk("flush_ctl", ctl_grp(), 32'b111);
        tick();
        BranchTaken = 1'b0;
        chk("flush_ex",  ex_grp(),  32'd0);
        chk("flush_mem", mem_grp(), 32'd0);
        chk("flush_wb_advances", wb_grp(), {24'd0, 3'b100, 5'd8});
`ifdef PERF_CNT_EN
        chk("perf_stall_cnt", {16'd0, StallCnt}, 32'd1);
        chk("perf_flush_cnt", {16'd0, FlushCnt}, 32'd1);
`endif

        // lw $0 never stalls; rt only matters when the consumer reads it
        IDInstr = itype(6'h23, 5'd1, 5'd0, 16'd0);
        tick();
        IDInstr = rtype(5'd0, 5'd2, 5'd6, 5'd0, 6'h20);
        #1;
        chk("lw_r0_no_stall", ctl_grp(), 32'b110);
        tick();
        IDInstr = itype(6'h23, 5'd1, 5'd5, 16'd0);
        tick();
        IDInstr = itype(6'h08, 5'd1, 5'd5, 16'd1);
        #1;
        chk("rt_unused_no_stall", ctl_grp(), 32'b110);
        tick();
        IDInstr = itype(6'h23, 5'd1, 5'd5, 16'd0);
        tick();
        IDInstr = itype(6'h2B, 5'd1, 5'd5, 16'd0);
        #1;
        chk("store_rt_stall", ctl_grp(), 32'b000);
        tick();

        // jal reaches WB with link, then asynchronous reset mid-stream
        IDInstr = jtype(6'h03, 26'h40);
        tick();
        IDInstr = 32'd0;
        tick();
        tick();
        chk("jal_wb", wb_grp(), {24'd0, 3'b101, 5'd31});
        IDInstr = itype(6'h23, 5'd1, 5'd9, 16'd0);
        tick();
        IDInstr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        tick();
        IDInstr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
        tick();
        chk("pre_reset_illegal", {31'd0, IllegalInstr}, 32'd1);
        #2;
        Rst_n       = 1'b0;
        BranchTaken = 1'b1;
        #1;
        chk("async_reset_ex",  ex_grp(),  32'd0);
        chk("async_reset_mem", mem_grp(), 32'd0);
        chk("async_reset_wb",  wb_grp(),  32'd0);
        chk("async_reset_ctl", ctl_grp(), 32'b110);
`ifdef PERF_CNT_EN
        chk("async_reset_cnt", {StallCnt, FlushCnt}, 32'd0);
`endif
        BranchTaken = 1'b0;
        Rst_n       = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
